// File: rtl/keypad_pkg.sv
// Shared lock-datapath definitions: debouncer state encoding and key code constants.
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      PRESSED    = 2'd2,
      DB_RELEASE = 2'd3
   } kp_state_t;

   localparam int KEY_HEX_MAX = 15;
   localparam int KEY_W       = 16;  // arm / enter
   localparam int KEY_X       = 17;
   localparam int KEY_Y       = 18;
   localparam int KEY_Z       = 19;

endpackage

// File: rtl/keypad_event_gen_if.sv
// Key event channel between the keypad front end (master) and the lock logic (slave).
interface keypad_event_gen_if #(
   parameter int CODE_W = 5
);
   import keypad_pkg::*;

   // key_valid/key_code hold until an edge where key_ready=1; key_ready is
   // ignored while key_valid=0; the master never withdraws a pending event.
   logic              key_valid;
   logic              key_ready;
   logic [CODE_W-1:0] key_code;
   logic              key_held;
   logic              overrun;
   kp_state_t         dbg_state;

   modport master (
      input  key_ready,
      output key_valid, key_code, key_held, overrun, dbg_state
   );

   modport slave (
      output key_ready,
      input  key_valid, key_code, key_held, overrun, dbg_state
   );

endinterface

// File: rtl/keypad_event_gen_kp_prio_enc.sv
// Combinational priority encoder: any = OR of inputs, code = highest set index.
module kp_prio_enc #(
   parameter int NKEYS  = 20,
   parameter int CODE_W = 5
) (
   input  logic [NKEYS-1:0]  i_s,
   output logic              o_any,
   output logic [CODE_W-1:0] o_code
);

   always_comb begin
      o_any  = |i_s;
      o_code = '0;
      for (int i = 0; i < NKEYS; i++) begin
         if (i_s[i]) o_code = CODE_W'(i);
      end
   end

endmodule

// File: rtl/keypad_event_gen.sv
// Keypad front end: synchronize, debounce and encode buttons into one event per press.
// Define KEYPAD_AUTOREPEAT_EN to re-emit the held key after a delay and then periodically.
module keypad_event_gen
   import keypad_pkg::*;
#(
   parameter int NKEYS           = KEY_Z + 1,
   parameter int CODE_W          = 5,
   parameter int DEBOUNCE_CYCLES = 3,
   parameter int REPEAT_DELAY    = 50,
   parameter int REPEAT_PERIOD   = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NKEYS-1:0]   pb_in,
   keypad_event_gen_if.master kp
);

   // An out-of-range parameter set never emits, so a bad build is obvious at once.
   localparam bit CFG_OK = (2**CODE_W >= NKEYS) && (DEBOUNCE_CYCLES >= 1) &&
                           (DEBOUNCE_CYCLES <= 15) && (REPEAT_DELAY >= 1) &&
                           (REPEAT_DELAY <= 255) && (REPEAT_PERIOD >= 1) &&
                           (REPEAT_PERIOD <= 255);
   localparam logic [3:0] DB_N = 4'(DEBOUNCE_CYCLES);

   logic [NKEYS-1:0]  r_sync1, r_sync2;
   logic              w_any;
   logic [CODE_W-1:0] w_code;

   kp_state_t         r_state;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_inc;
   logic [CODE_W-1:0] r_cand;
   logic              r_held;

   logic              w_emit;
   logic [CODE_W-1:0] w_emit_code;
   logic              r_valid;
   logic [CODE_W-1:0] r_code;
   logic              r_overrun;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam logic [7:0] RPT_DLY = 8'(REPEAT_DELAY);
   localparam logic [7:0] RPT_PER = 8'(REPEAT_PERIOD);
   logic [7:0] r_rpt;
   logic       r_rpt_per;
   logic [7:0] w_rpt_inc;
   logic [7:0] w_rpt_lim;
   assign w_rpt_inc = r_rpt + 8'd1;
   assign w_rpt_lim = r_rpt_per ? RPT_PER : RPT_DLY;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= pb_in;
         r_sync2 <= r_sync1;
      end
   end

   kp_prio_enc #(
      .NKEYS  (NKEYS),
      .CODE_W (CODE_W)
   ) u_prio_enc (
      .i_s    (r_sync2),
      .o_any  (w_any),
      .o_code (w_code)
   );

   assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

   always_comb begin
      w_emit      = 1'b0;
      w_emit_code = r_cand;
      case (r_state)
         IDLE: begin
            if (w_any && DB_N == 4'd1) begin
               w_emit      = CFG_OK;
               w_emit_code = w_code;
            end
         end
         DB_PRESS: begin
            if (w_any && w_code == r_cand && w_cnt_inc >= DB_N) w_emit = CFG_OK;
         end
`ifdef KEYPAD_AUTOREPEAT_EN
         PRESSED: begin
            if (w_any && w_rpt_inc == w_rpt_lim) w_emit = CFG_OK;
         end
`endif
         default: ;
      endcase
   end

   // Debounce FSM; r_cnt counts consecutive agreeing samples, including the first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_cand  <= '0;
         r_held  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_cand <= w_code;
                  r_cnt  <= 4'd1;
                  if (DB_N == 4'd1) begin
                     r_state <= PRESSED;
                     r_held  <= 1'b1;
                  end else begin
                     r_state <= DB_PRESS;
                  end
               end
            end
            DB_PRESS: begin
               if (!w_any || w_code != r_cand) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc >= DB_N) begin
                     r_state <= PRESSED;
                     r_held  <= 1'b1;
                  end
               end
            end
            PRESSED: begin
               if (!w_any) begin
                  r_cnt <= 4'd1;
                  if (DB_N == 4'd1) begin
                     r_state <= IDLE;
                     r_held  <= 1'b0;
                  end else begin
                     r_state <= DB_RELEASE;
                  end
               end
            end
            DB_RELEASE: begin
               if (w_any) begin
                  r_state <= PRESSED;
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc >= DB_N) begin
                     r_state <= IDLE;
                     r_held  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_held  <= 1'b0;
            end
         endcase
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   // Repeat timer runs only while settled in PRESSED; any excursion restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rpt     <= '0;
         r_rpt_per <= 1'b0;
      end else if (r_state == PRESSED && w_any) begin
         if (w_rpt_inc == w_rpt_lim) begin
            r_rpt     <= '0;
            r_rpt_per <= 1'b1;
         end else begin
            r_rpt <= w_rpt_inc;
         end
      end else begin
         r_rpt     <= '0;
         r_rpt_per <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_code    <= '0;
         r_overrun <= 1'b0;
      end else if (w_emit) begin
         if (!r_valid || kp.key_ready) begin
            r_valid <= 1'b1;
            r_code  <= w_emit_code;
         end else begin
            r_overrun <= 1'b1;
         end
      end else if (r_valid && kp.key_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign kp.key_valid = r_valid;
   assign kp.key_code  = r_code;
   assign kp.key_held  = r_held;
   assign kp.overrun   = r_overrun;
   assign kp.dbg_state = r_state;

endmodule

// File: tb/tb_keypad_event_gen.sv
// Self-checking bench for keypad_event_gen: directed scenarios plus a random run against a reference model.
module tb_keypad_event_gen;
   import keypad_pkg::*;

   localparam int NKEYS  = 20;
   localparam int CODE_W = 5;
   localparam int D      = 3;
   localparam int RD     = 50;
   localparam int RP     = 10;

   logic             clk = 1'b0;
   logic             rst;
   logic [NKEYS-1:0] pb_in;

   keypad_event_gen_if #(.CODE_W(CODE_W)) kp();

   keypad_event_gen #(
      .NKEYS           (NKEYS),
      .CODE_W          (CODE_W),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .pb_in (pb_in),
      .kp    (kp)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- reference model (run-length view of the rules) ----------------
   logic [NKEYS-1:0]  m_p1 = '0, m_p2 = '0;
   bit                m_held = 0, m_valid = 0, m_ovr = 0;
   int                m_run = 0, m_cand = 0, m_rel = 0, m_age = 0, m_code = 0;
   bit                m_any, m_emit;
   int                m_top, m_ecode;
   logic [CODE_W-1:0] exp_q[$];
   logic [CODE_W-1:0] got_q[$];

   function automatic int top_index(logic [NKEYS-1:0] v);
      for (int i = NKEYS - 1; i >= 0; i--) if (v[i]) return i;
      return 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_p1 = '0; m_p2 = '0;
         m_held = 0; m_valid = 0; m_ovr = 0;
         m_run = 0; m_cand = 0; m_rel = 0; m_age = 0; m_code = 0;
         exp_q.delete();
      end else begin
         m_any  = |m_p2;
         m_top  = top_index(m_p2);
         m_emit = 0;
         m_ecode = 0;
         if (!m_held) begin
            if (!m_any) m_run = 0;
            else if (m_run == 0) begin m_cand = m_top; m_run = 1; end
            else if (m_top != m_cand) m_run = 0;
            else m_run++;
            if (m_any && m_run >= D) begin
               m_emit = 1; m_ecode = m_cand;
               m_held = 1; m_rel = 0; m_age = 0; m_run = 0;
            end
         end else if (m_any) begin
            if (m_rel > 0) begin
               m_rel = 0; m_age = 0;
            end else begin
               m_age++;
`ifdef KEYPAD_AUTOREPEAT_EN
               if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)) begin
                  m_emit = 1; m_ecode = m_cand;
               end
`endif
            end
         end else begin
            m_rel++; m_age = 0;
            if (m_rel >= D) begin m_held = 0; m_rel = 0; end
         end
         if (m_emit) begin
            if (!m_valid || kp.key_ready) begin
               m_valid = 1; m_code = m_ecode;
               exp_q.push_back(CODE_W'(m_ecode));
            end else begin
               m_ovr = 1;
            end
         end else if (m_valid && kp.key_ready) begin
            m_valid = 0;
         end
         m_p2 = m_p1;
         m_p1 = pb_in;
      end
   end

   // Accepted events as seen on the DUT's channel.
   always @(posedge clk) begin
      if (!rst && kp.key_valid === 1'b1 && kp.key_ready === 1'b1) got_q.push_back(kp.key_code);
   end

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: cycle budget of 50000 expired");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1; pb_in = '0; kp.key_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      got_q.delete();
   endtask

   task automatic press_only(input int key);
      pb_in = '0;
      pb_in[key] = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      n_checks++; if (kp.key_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", kp.key_valid); else n_pass++;
      n_checks++; if (kp.key_code !== '0) $display("FAIL reset_code got=%0d exp=0", kp.key_code); else n_pass++;
      n_checks++; if (kp.key_held !== 1'b0) $display("FAIL reset_held got=%b exp=0", kp.key_held); else n_pass++;
      n_checks++; if (kp.overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", kp.overrun); else n_pass++;
      n_checks++; if (kp.dbg_state !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", kp.dbg_state, IDLE); else n_pass++;
   endtask

   task automatic test_clean_press();
      kp.key_ready = 1'b1;
      got_q.delete();
      press_only(7);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         n_checks++; if (kp.key_valid !== (k == D + 2)) $display("FAIL clean_valid edge=%0d got=%b exp=%b", k, kp.key_valid, (k == D + 2)); else n_pass++;
         n_checks++; if (kp.key_held !== (k >= D + 2)) $display("FAIL clean_held edge=%0d got=%b exp=%b", k, kp.key_held, (k >= D + 2)); else n_pass++;
         if (k == D + 2) begin
            n_checks++; if (kp.key_code !== 5'd7) $display("FAIL clean_code got=%0d exp=7", kp.key_code); else n_pass++;
         end
      end
      pb_in = '0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         n_checks++; if (kp.key_held !== (k < D + 2)) $display("FAIL clean_release_held edge=%0d got=%b exp=%b", k, kp.key_held, (k < D + 2)); else n_pass++;
         n_checks++; if (kp.key_valid !== 1'b0) $display("FAIL clean_no_second got=%b exp=0", kp.key_valid); else n_pass++;
      end
      n_checks++; if (got_q.size() != 1) $display("FAIL clean_event_count got=%0d exp=1", got_q.size()); else n_pass++;
   endtask

   task automatic test_bounce_press();
      kp.key_ready = 1'b1;
      got_q.delete();
      for (int t = 0; t < 4; t++) begin
         if (t % 2 == 0) press_only(3); else pb_in = '0;
         @(negedge clk);
         n_checks++; if (kp.key_valid !== 1'b0) $display("FAIL bounce_press_quiet step=%0d got=%b exp=0", t, kp.key_valid); else n_pass++;
      end
      press_only(3);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         n_checks++; if (kp.key_valid !== (k == D + 2)) $display("FAIL bounce_press_valid edge=%0d got=%b exp=%b", k, kp.key_valid, (k == D + 2)); else n_pass++;
         if (k == D + 2) begin
            n_checks++; if (kp.key_code !== 5'd3) $display("FAIL bounce_press_code got=%0d exp=3", kp.key_code); else n_pass++;
         end
      end
      pb_in = '0;
      repeat (8) @(negedge clk);
      n_checks++; if (got_q.size() != 1) $display("FAIL bounce_press_count got=%0d exp=1", got_q.size()); else n_pass++;
   endtask

   task automatic test_bounce_release();
      logic [CODE_W-1:0] first;
      kp.key_ready = 1'b1;
      got_q.delete();
      press_only(KEY_W);
      repeat (8) @(negedge clk);
      pb_in = '0;
      @(negedge clk);
      press_only(KEY_W);
      repeat (6) @(negedge clk);
      n_checks++; if (kp.key_held !== 1'b1) $display("FAIL bounce_release_held got=%b exp=1", kp.key_held); else n_pass++;
      pb_in = '0;
      repeat (10) @(negedge clk);
      n_checks++; if (kp.key_held !== 1'b0) $display("FAIL bounce_release_free got=%b exp=0", kp.key_held); else n_pass++;
      n_checks++; if (got_q.size() != 1) $display("FAIL bounce_release_count got=%0d exp=1", got_q.size()); else n_pass++;
      first = (got_q.size() > 0) ? got_q[0] : '1;
      n_checks++; if (first !== CODE_W'(KEY_W)) $display("FAIL bounce_release_code got=%0d exp=%0d", first, KEY_W); else n_pass++;
   endtask

   task automatic test_priority();
      kp.key_ready = 1'b1;
      press_only(0);
      repeat (D + 2) @(negedge clk);
      n_checks++; if (kp.key_valid !== 1'b1) $display("FAIL prio_pb0_valid got=%b exp=1", kp.key_valid); else n_pass++;
      n_checks++; if (kp.key_code !== 5'd0) $display("FAIL prio_pb0_code got=%0d exp=0", kp.key_code); else n_pass++;
      pb_in = '0;
      repeat (8) @(negedge clk);
      pb_in = '0; pb_in[2] = 1'b1; pb_in[12] = 1'b1;
      repeat (D + 2) @(negedge clk);
      n_checks++; if (kp.key_valid !== 1'b1) $display("FAIL prio_2_12_valid got=%b exp=1", kp.key_valid); else n_pass++;
      n_checks++; if (kp.key_code !== 5'd12) $display("FAIL prio_2_12_code got=%0d exp=12", kp.key_code); else n_pass++;
      pb_in = '0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_backpressure();
      kp.key_ready = 1'b0;
      got_q.delete();
      press_only(5);
      repeat (D + 2) @(negedge clk);
      n_checks++; if (kp.key_valid !== 1'b1) $display("FAIL bp_first_valid got=%b exp=1", kp.key_valid); else n_pass++;
      n_checks++; if (kp.overrun !== 1'b0) $display("FAIL bp_first_overrun got=%b exp=0", kp.overrun); else n_pass++;
      @(negedge clk);
      pb_in = '0;
      repeat (6) @(negedge clk);
      press_only(9);
      repeat (6) @(negedge clk);
      pb_in = '0;
      repeat (6) @(negedge clk);
      n_checks++; if (kp.key_valid !== 1'b1) $display("FAIL bp_hold_valid got=%b exp=1", kp.key_valid); else n_pass++;
      n_checks++; if (kp.key_code !== 5'd5) $display("FAIL bp_hold_code got=%0d exp=5", kp.key_code); else n_pass++;
      n_checks++; if (kp.overrun !== 1'b1) $display("FAIL bp_overrun_set got=%b exp=1", kp.overrun); else n_pass++;
      kp.key_ready = 1'b1;
      @(negedge clk);
      kp.key_ready = 1'b0;
      n_checks++; if (kp.key_valid !== 1'b0) $display("FAIL bp_accept_valid got=%b exp=0", kp.key_valid); else n_pass++;
      n_checks++; if (kp.overrun !== 1'b1) $display("FAIL bp_overrun_sticky got=%b exp=1", kp.overrun); else n_pass++;
      n_checks++; if (got_q.size() != 1) $display("FAIL bp_accept_count got=%0d exp=1", got_q.size()); else n_pass++;
   endtask

   task automatic test_reset_mid();
      kp.key_ready = 1'b1;
      press_only(11);
      repeat (3) @(negedge clk);
      n_checks++; if (kp.dbg_state !== DB_PRESS) $display("FAIL mid_state_pre got=%0d exp=%0d", kp.dbg_state, DB_PRESS); else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++; if (kp.dbg_state !== IDLE) $display("FAIL mid_state got=%0d exp=%0d", kp.dbg_state, IDLE); else n_pass++;
      n_checks++; if (kp.key_valid !== 1'b0) $display("FAIL mid_valid got=%b exp=0", kp.key_valid); else n_pass++;
      n_checks++; if (kp.key_code !== '0) $display("FAIL mid_code got=%0d exp=0", kp.key_code); else n_pass++;
      n_checks++; if (kp.key_held !== 1'b0) $display("FAIL mid_held got=%b exp=0", kp.key_held); else n_pass++;
      n_checks++; if (kp.overrun !== 1'b0) $display("FAIL mid_overrun got=%b exp=0", kp.overrun); else n_pass++;
      pb_in = '0;
      @(negedge clk);
      rst = 1'b0;
      got_q.delete();
   endtask

   task automatic test_autorepeat();
      int seen[$];
      int want[$];
`ifdef KEYPAD_AUTOREPEAT_EN
      want = '{D + 2, D + 2 + RD, D + 2 + RD + RP, D + 2 + RD + 2 * RP};
`else
      want = '{D + 2};
`endif
      kp.key_ready = 1'b1;
      press_only(4);
      for (int k = 1; k <= 80; k++) begin
         @(negedge clk);
         if (kp.key_valid === 1'b1) seen.push_back(k);
      end
      pb_in = '0;
      repeat (8) @(negedge clk);
      n_checks++; if (seen.size() != want.size()) $display("FAIL repeat_count got=%0d exp=%0d", seen.size(), want.size()); else n_pass++;
      for (int i = 0; i < want.size(); i++) begin
         n_checks++;
         if (i >= seen.size() || seen[i] != want[i])
            $display("FAIL repeat_edge idx=%0d got=%0d exp=%0d", i, (i < seen.size()) ? seen[i] : -1, want[i]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [NKEYS-1:0] cur;
      int left;
      int t;
      do_reset();
      cur = '0;
      left = 0;
      for (int c = 0; c < 2500; c++) begin
         if (left == 0) begin
            cur = '0;
            if ($urandom_range(0, 2) != 0) begin
               t = $urandom_range(0, NKEYS - 1);
               cur[t] = 1'b1;
               for (int i = 0; i < t; i++) cur[i] = ($urandom_range(0, 3) == 0);
            end
            left = $urandom_range(1, 12);
         end
         left--;
         if ($urandom_range(0, 4) == 0) pb_in = $urandom_range(0, 1) ? '0 : NKEYS'($urandom);
         else pb_in = cur;
         kp.key_ready = ($urandom_range(0, 3) != 0);
         if (c >= 2480) begin pb_in = '0; kp.key_ready = 1'b1; end
         @(negedge clk);
         n_checks++; if (kp.key_valid !== m_valid) $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, kp.key_valid, m_valid); else n_pass++;
         n_checks++; if (kp.key_code !== CODE_W'(m_code)) $display("FAIL rand_code cyc=%0d got=%0d exp=%0d", c, kp.key_code, m_code); else n_pass++;
         n_checks++; if (kp.key_held !== m_held) $display("FAIL rand_held cyc=%0d got=%b exp=%b", c, kp.key_held, m_held); else n_pass++;
         n_checks++; if (kp.overrun !== m_ovr) $display("FAIL rand_overrun cyc=%0d got=%b exp=%b", c, kp.overrun, m_ovr); else n_pass++;
      end
      n_checks++; if (got_q.size() != exp_q.size()) $display("FAIL rand_event_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_event idx=%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]); else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1;
      pb_in = '0;
      kp.key_ready = 1'b0;
      do_reset();
      test_reset();
      test_clean_press();
      test_bounce_press();
      test_bounce_release();
      test_priority();
      test_backpressure();
      test_reset_mid();
      test_autorepeat();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/keypad_event_gen.md
Name: keypad_event_gen

Overview:
- Front end for the lock datapath. Turns raw, bouncing, asynchronous push-button lines into clean key events on the 100 Hz system clock.
- Each debounced press produces exactly one event (encoded key code) on a valid/ready handshake.
- The lock FSM and password shift register consume these events synchronously on clk, so no strobe-derived clock is needed anywhere downstream.

Parameters:
- NKEYS, 20, number of button inputs.
- CODE_W, 5, key code width; must satisfy 2**CODE_W >= NKEYS.
- DEBOUNCE_CYCLES, 3, consecutive stable samples required for press and for release; legal range 1..15.
- REPEAT_DELAY, 50, cycles a key is held before the first auto-repeat (feature only).
- REPEAT_PERIOD, 10, cycles between subsequent auto-repeats (feature only).

Ports:
- clk  input  1  system clock (hz100).
- rst  input  1  asynchronous, active-high reset.
- pb_in  input  NKEYS  raw button levels, asynchronous, 1 = pressed.
- key_ready  input  1  consumer accepts the pending event on a clk edge where key_valid=1.
- key_valid  output  1  an event is pending.
- key_code  output  CODE_W  code of the pending event; stable while key_valid=1.
- key_held  output  1  the debounced key is currently held (state PRESSED or DB_RELEASE).
- overrun  output  1  sticky flag: an event was dropped because the previous one was not accepted.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, counter 0, synchronizer flops 0, key_valid 0, key_code 0, key_held 0, overrun 0. A reset mid-debounce or mid-handshake discards everything.
- Synchronizer: two-flop synchronizer on every pb_in bit; all logic below uses the synchronized vector s.
- Encoding: any = |s. code = index of the highest set bit of s; code = 0 when only s[0] is set. code is meaningful only when any=1.
- State machine states: IDLE, DB_PRESS, PRESSED, DB_RELEASE.
- IDLE:
  - any=1: latch cand=code, cnt=1, go to DB_PRESS.
  - If DEBOUNCE_CYCLES=1, emit immediately and go to PRESSED instead.
- DB_PRESS:
  - any=0: back to IDLE.
  - any=1 but code differs from cand: back to IDLE.
  - Otherwise cnt++. When cnt reaches DEBOUNCE_CYCLES, emit cand and go to PRESSED.
- PRESSED:
  - any=0: cnt=1, go to DB_RELEASE.
  - A code change while any=1 is ignored; there is no new event until a full release.
- DB_RELEASE:
  - any=1: back to PRESSED.
  - Otherwise cnt++. At DEBOUNCE_CYCLES, go to IDLE.
- Latency: with pb_in stable and high from before edge 1, key_valid is first high after edge DEBOUNCE_CYCLES+2 (edge 5 for the default).
- Emit / handshake:
  - Emit while key_valid=0: load key_code and set key_valid=1.
  - key_valid=1 and key_ready=1 at an edge: key_valid clears that edge.
  - Emit on the same edge as an accept: the new code loads and key_valid stays 1.
  - Emit while key_valid=1 and key_ready=0: the new event is dropped, key_code is unchanged, and overrun is set. overrun stays 1 until rst.
  - key_ready while key_valid=0 has no effect.
- Counter: 4 bits, saturating; it never wraps.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In PRESSED, a separate 8-bit repeat counter runs from entry into PRESSED.
  - The same code is re-emitted after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles while the key stays in PRESSED.
  - Repeat emits follow the same handshake and overrun rules.
  - Leaving PRESSED resets the repeat counter; bouncing back from DB_RELEASE restarts it at 0.
- Undefined: exactly one event per press; the repeat counter and REPEAT_* parameters are unused.

Decomposition:
- Shared package keypad_pkg holds:
  - kp_state_t enum {IDLE, DB_PRESS, PRESSED, DB_RELEASE}.
  - Key code constants: KEY_W=16 (arm/enter), KEY_X=17, KEY_Y=18, KEY_Z=19, and KEY_HEX_MAX=15.
- The lock FSM imports the same constants.
- One natural sub-module: kp_prio_enc, the combinational NKEYS-to-CODE_W priority encoder producing any and code.

Test Plan:
- Clean press: pb_in[7]=1 held 10 cycles, key_ready=1 → key_valid high for exactly one cycle after edge 5 with key_code=7. key_held=1 until DEBOUNCE_CYCLES cycles after release. No second event.
- Bounce on press: pb_in[3] toggles 1,0,1,0 on consecutive cycles, then stays 1 → no event during the toggling. One event with code 3 follows DEBOUNCE_CYCLES+2 cycles after the last toggle.
- Bounce on release: press pb_in[16], release for 1 cycle, re-press, then release fully → exactly one event with code 16.
- Priority and pb[0]: pb_in[0]=1 alone gives code 0 with valid=1. pb_in[2] and pb_in[12] together give code 12.
- Backpressure: key_ready=0; press key 5, release, press key 9 → key_valid stays 1 with key_code=5 and overrun=1. Then key_ready=1 for one cycle → key_valid=0, and overrun remains 1.
- Reset mid-debounce, plus repeat: assert rst during DB_PRESS → all outputs 0 and state IDLE. With KEYPAD_AUTOREPEAT_EN, hold key 4 for 80 cycles → events at about 5, 55, 65 and 75 cycles after the press.
